// File: rtl/sm83_irq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sm83_irq_pkg
//  Purpose  : Shared types and constants for the SM83 interrupt dispatcher.
//             State encoding of the dispatch sequencer, default vector
//             placement and a helper that maps a source index to its vector.
//  Revision : 1.0 - initial release
// ============================================================================
package sm83_irq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT0   = 3'd1,
        WAIT1   = 3'd2,
        PUSH_HI = 3'd3,
        PUSH_LO = 3'd4,
        JUMP    = 3'd5
    } irq_state_t;

    localparam int          C_N_IRQ      = 5;
    localparam logic [15:0] C_VEC_BASE   = 16'h0040;
    localparam int          C_VEC_STRIDE = 8;

    // Target PC of source idx: base + idx * stride, truncated to 16 bits.
    function automatic logic [15:0] vec_addr(input logic [15:0] base,
                                             input int          stride,
                                             input int          idx);
        return base + 16'(stride * idx);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sm83_irq_prio.sv
`default_nettype none
// ============================================================================
//  Module   : sm83_irq_prio
//  Purpose  : Combinational fixed-priority encoder. Bit 0 has the highest
//             priority (lowest set index wins).
//  Ports    : i_pending  - request vector
//             o_valid    - at least one request present
//             o_idx      - index of the winning request (0 when none)
//             o_onehot   - one-hot of the winning request (0 when none)
//  Revision : 1.0 - initial release
// ============================================================================
module sm83_irq_prio #(
    parameter int N_IRQ = 5,
    parameter int IDX_W = 3
) (
    input  logic [N_IRQ-1:0] i_pending,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx,
    output logic [N_IRQ-1:0] o_onehot
);

    // Scan from the top down so the lowest set index is the last writer.
    always_comb begin
        o_valid  = 1'b0;
        o_idx    = '0;
        o_onehot = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (i_pending[i]) begin
                o_valid     = 1'b1;
                o_idx       = IDX_W'(i);
                o_onehot    = '0;
                o_onehot[i] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sm83_irq_dispatch.sv
`default_nettype none
// ============================================================================
//  Module   : sm83_irq_dispatch
//  Purpose  : SM83 interrupt dispatcher. Masks the latched requests with IE,
//             raises HALT wake-up, and sequences the 5-M-cycle dispatch
//             (WAIT0, WAIT1, PUSH_HI, PUSH_LO, JUMP).
//  Ports    : clk, reset_n (sync, active-low), m_tick (M-cycle strobe)
//             irq_q_n/ie/ime    - request inputs (requests active-low)
//             fetch_boundary    - instruction boundary, sampled with m_tick
//             halted            - core in HALT
//             busy              - sequence in progress
//             clr_ime           - one-clk pulse after dispatch entry
//             push_hi/push_lo/jump - M-cycle decodes for bus / PC sequencers
//             ack               - one-clk one-hot clear of serviced latch
//             vector            - resolved target PC
//             wake              - registered HALT exit request
//  Revision : 1.0 - initial release
// ============================================================================
module sm83_irq_dispatch
    import sm83_irq_pkg::*;
#(
    parameter int          N_IRQ      = C_N_IRQ,
    parameter logic [15:0] VEC_BASE   = C_VEC_BASE,
    parameter int          VEC_STRIDE = C_VEC_STRIDE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             m_tick,
    input  logic [N_IRQ-1:0] irq_q_n,
    input  logic [N_IRQ-1:0] ie,
    input  logic             ime,
    input  logic             fetch_boundary,
    input  logic             halted,
    output logic             busy,
    output logic             clr_ime,
    output logic             push_hi,
    output logic             push_lo,
    output logic             jump,
    output logic [N_IRQ-1:0] ack,
    output logic [15:0]      vector,
    output logic             wake
);

    localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    irq_state_t       r_state;
    irq_state_t       w_state_nxt;

    logic [N_IRQ-1:0] w_pending;
    logic             w_any_pending;
    logic             w_entry;
    logic             w_resolve;
    logic             w_valid;
    logic [IDX_W-1:0] w_idx;
    logic [N_IRQ-1:0] w_onehot;
    logic [15:0]      w_vec_res;

    logic             r_busy;
    logic             r_clr_ime;
    logic             r_push_hi;
    logic             r_push_lo;
    logic             r_jump;
    logic [N_IRQ-1:0] r_ack;
    logic [N_IRQ-1:0] r_ack_sel;
    logic [15:0]      r_vector;
    logic             r_wake;

    assign w_pending     = ~irq_q_n & ie;
    assign w_any_pending = |w_pending;

    // Entry is allowed from IDLE, and also on the tick that ends JUMP so
    // back-to-back dispatches need no idle M-cycle between them.
    assign w_entry = m_tick & fetch_boundary & ime & w_any_pending &
                     ((r_state == IDLE) || (r_state == JUMP));

    // Late resolution: pending is sampled as the PUSH_HI cycle closes, so an
    // IE write by the high-byte push can still cancel the dispatch.
    assign w_resolve = m_tick & (r_state == PUSH_HI);

    sm83_irq_prio #(
        .N_IRQ (N_IRQ),
        .IDX_W (IDX_W)
    ) u_prio (
        .i_pending (w_pending),
        .o_valid   (w_valid),
        .o_idx     (w_idx),
        .o_onehot  (w_onehot)
    );

    assign w_vec_res = w_valid ? vec_addr(VEC_BASE, VEC_STRIDE, int'(w_idx))
                               : 16'h0000;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_entry) w_state_nxt = WAIT0;
            WAIT0:   if (m_tick)  w_state_nxt = WAIT1;
            WAIT1:   if (m_tick)  w_state_nxt = PUSH_HI;
            PUSH_HI: if (m_tick)  w_state_nxt = PUSH_LO;
            PUSH_LO: if (m_tick)  w_state_nxt = JUMP;
            JUMP:    if (m_tick)  w_state_nxt = w_entry ? WAIT0 : IDLE;
            default:              w_state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up exactly
    // with r_state; clr_ime and ack derive from single-edge events and are
    // therefore one clk wide even when m_tick is held high.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_busy    <= 1'b0;
            r_clr_ime <= 1'b0;
            r_push_hi <= 1'b0;
            r_push_lo <= 1'b0;
            r_jump    <= 1'b0;
            r_ack     <= '0;
            r_ack_sel <= '0;
            r_vector  <= 16'h0000;
            r_wake    <= 1'b0;
        end else begin
            r_busy    <= (w_state_nxt != IDLE);
            r_clr_ime <= w_entry;
            r_push_hi <= (w_state_nxt == PUSH_HI);
            r_push_lo <= (w_state_nxt == PUSH_LO);
            r_jump    <= (w_state_nxt == JUMP);
            r_ack     <= (m_tick && (r_state == PUSH_LO)) ? r_ack_sel : '0;
            if (w_resolve) begin
                r_vector  <= w_vec_res;
                r_ack_sel <= w_onehot;
            end
            r_wake    <= halted & w_any_pending;
        end
    end

    assign busy    = r_busy;
    assign clr_ime = r_clr_ime;
    assign push_hi = r_push_hi;
    assign push_lo = r_push_lo;
    assign jump    = r_jump;
    assign ack     = r_ack;
    assign vector  = r_vector;
    assign wake    = r_wake;

endmodule
`default_nettype wire

// File: tb/tb_sm83_irq_dispatch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sm83_irq_dispatch
//  Purpose  : Directed self-checking bench for sm83_irq_dispatch. Expected
//             ack/vector pairs are queued when a dispatch is started and
//             compared when jump rises.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sm83_irq_dispatch;

    localparam int N = 5;

    logic          clk            = 1'b0;
    logic          reset_n        = 1'b0;
    logic          m_tick         = 1'b0;
    logic [N-1:0]  irq_q_n        = '1;
    logic [N-1:0]  ie             = '0;
    logic          ime            = 1'b0;
    logic          fetch_boundary = 1'b0;
    logic          halted         = 1'b0;
    logic          busy;
    logic          clr_ime;
    logic          push_hi;
    logic          push_lo;
    logic          jump;
    logic [N-1:0]  ack;
    logic [15:0]   vector;
    logic          wake;

    typedef struct packed {
        logic [N-1:0] ack;
        logic [15:0]  vec;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks     = 0;
    int   errors     = 0;
    int   ack_pulses = 0;
    int   ack_w      = 0;
    int   clr_w      = 0;
    logic prev_jump  = 1'b0;

    always #5 clk = ~clk;

    sm83_irq_dispatch #(
        .N_IRQ      (N),
        .VEC_BASE   (16'h0040),
        .VEC_STRIDE (8)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .m_tick         (m_tick),
        .irq_q_n        (irq_q_n),
        .ie             (ie),
        .ime            (ime),
        .fetch_boundary (fetch_boundary),
        .halted         (halted),
        .busy           (busy),
        .clr_ime        (clr_ime),
        .push_hi        (push_hi),
        .push_lo        (push_lo),
        .jump           (jump),
        .ack            (ack),
        .vector         (vector),
        .wake           (wake)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer and pulse-width monitor.
    always @(negedge clk) begin
        if (jump && !prev_jump) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_jump", sb.size(), 1);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_ack", ack, mon_e.ack);
                chk("sb_vector", vector, mon_e.vec);
            end
        end
        prev_jump = jump;
        if (ack != '0) begin
            if (ack_w == 0) ack_pulses++;
            ack_w++;
        end else begin
            if (ack_w != 0) chk("ack_width", ack_w, 1);
            ack_w = 0;
        end
        if (clr_ime) begin
            clr_w++;
        end else begin
            if (clr_w != 0) chk("clr_ime_width", clr_w, 1);
            clr_w = 0;
        end
    end

    task automatic do_tick();
        m_tick = 1'b1;
        @(negedge clk);
        m_tick = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_entry(input string tag);
        fetch_boundary = 1'b1;
        do_tick();
        chk({tag, "_clr_ime"}, clr_ime, 1);
        chk({tag, "_busy"}, busy, 1);
        fetch_boundary = 1'b0;
        @(negedge clk);
        chk({tag, "_clr_ime_low"}, clr_ime, 0);
    endtask

    // Walks a sequence from WAIT0 to IDLE, checking the phase decodes both
    // mid-M-cycle and right after each tick. At step mod_n the request
    // inputs are overwritten before that step's tick.
    task automatic run_seq(input string tag, input int mod_n,
                           input logic [N-1:0] mod_ie, input logic [N-1:0] mod_irq);
        logic [2:0] ph [0:5];
        int n;
        ph = '{3'b000, 3'b000, 3'b100, 3'b010, 3'b001, 3'b000};
        n  = 0;
        while (busy && n < 12) begin
            idle(1);
            chk({tag, "_phase_hold"}, {push_hi, push_lo, jump}, (n < 6) ? ph[n] : 3'b111);
            if (n == mod_n) begin
                ie      = mod_ie;
                irq_q_n = mod_irq;
            end
            do_tick();
            n++;
            chk({tag, "_phase"}, {push_hi, push_lo, jump}, (n < 6) ? ph[n] : 3'b111);
        end
        chk({tag, "_mticks"}, n, 5);
    endtask

    initial begin
        // Reset wins over a qualifying entry and a HALT wake condition.
        reset_n = 1'b0; halted = 1'b1; ime = 1'b1; ie = 5'h1F;
        irq_q_n = 5'b10101; fetch_boundary = 1'b1; m_tick = 1'b1;
        idle(3);
        chk("reset_outputs", {busy, clr_ime, push_hi, push_lo, jump, wake, ack, vector}, 0);
        m_tick = 1'b0; fetch_boundary = 1'b0; halted = 1'b0; reset_n = 1'b1;
        idle(2);
        chk("idle_busy", busy, 0);

        // T1: sources 1 and 3 pending -> source 1.
        sb.push_back('{ack: 5'b00010, vec: 16'h0048});
        do_entry("t1");
        run_seq("t1", -1, 5'h1F, 5'b10101);
        chk("t1_vector_hold", vector, 16'h0048);

        // fetch_boundary low suppresses entry.
        idle(2);
        do_tick();
        chk("no_boundary_busy", busy, 0);
        chk("no_boundary_clr", clr_ime, 0);

        // T2: IE cleared during PUSH_HI -> null vector, no ack.
        sb.push_back('{ack: 5'b00000, vec: 16'h0000});
        do_entry("t2");
        run_seq("t2", 2, 5'h00, 5'b10101);
        ie = 5'h1F;

        // T3: source 4 at entry, source 0 raised during WAIT1.
        irq_q_n = 5'b01111;
        sb.push_back('{ack: 5'b00001, vec: 16'h0040});
        do_entry("t3");
        run_seq("t3", 1, 5'h1F, 5'b01110);

        // T4: HALT wake with IME clear.
        ime = 1'b0; irq_q_n = 5'b11011; halted = 1'b1; fetch_boundary = 1'b1;
        @(negedge clk);
        chk("wake_rise", wake, 1);
        do_tick();
        chk("wake_no_busy", busy, 0);
        chk("wake_no_clr", clr_ime, 0);
        ie = 5'h00;
        @(negedge clk);
        chk("wake_masked", wake, 0);
        ie = 5'h1F;
        @(negedge clk);
        chk("wake_unmasked", wake, 1);
        irq_q_n = 5'b11111;
        @(negedge clk);
        chk("wake_fall", wake, 0);
        halted = 1'b0; fetch_boundary = 1'b0; ime = 1'b1;

        // T5: reset during PUSH_LO aborts with no ack.
        irq_q_n = 5'b10101;
        do_entry("t5");
        repeat (3) begin
            idle(1);
            do_tick();
        end
        chk("t5_in_push_lo", push_lo, 1);
        reset_n = 1'b0; m_tick = 1'b1;
        @(negedge clk);
        chk("t5_reset_outputs", {busy, clr_ime, push_hi, push_lo, jump, wake, ack, vector}, 0);
        m_tick = 1'b0; reset_n = 1'b1;
        repeat (4) begin
            idle(1);
            do_tick();
        end
        chk("t5_stays_idle", busy, 0);

        // T6: m_tick held high, then back-to-back entry on the JUMP tick.
        irq_q_n = 5'b10111;
        sb.push_back('{ack: 5'b01000, vec: 16'h0058});
        fetch_boundary = 1'b1; m_tick = 1'b1;
        @(negedge clk);
        chk("t6_clr_ime", clr_ime, 1);
        fetch_boundary = 1'b0;
        @(negedge clk);
        chk("t6_clr_ime_low", clr_ime, 0);
        @(negedge clk);
        chk("t6_push_hi", push_hi, 1);
        m_tick = 1'b0;
        idle(2);
        m_tick = 1'b1;
        @(negedge clk);
        chk("t6_push_lo", push_lo, 1);
        chk("t6_vector", vector, 16'h0058);
        fetch_boundary = 1'b1;
        sb.push_back('{ack: 5'b01000, vec: 16'h0058});
        @(negedge clk);
        chk("t6_jump", jump, 1);
        @(negedge clk);
        chk("t6_reentry_busy", busy, 1);
        chk("t6_reentry_clr", clr_ime, 1);
        chk("t6_reentry_ack_low", ack, 0);
        m_tick = 1'b0; fetch_boundary = 1'b0;
        run_seq("t6b", -1, 5'h1F, 5'b10111);

        idle(3);
        chk("sb_empty", sb.size(), 0);
        chk("ack_pulse_count", ack_pulses, 4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
